// File: rtl/example_7.sv
// example_7: WIDTH-bit synchronous up-counter with parallel load and
// ripple-carry output for cascading.
//
// Ports:
//   CLK     in   rising-edge clock
//   Clear   in   synchronous active-high reset (wins over Load and Count)
//   Data_in in   parallel load value (WIDTH)
//   Count   in   active-high count enable
//   Load    in   active-high parallel load (wins over Count)
//   A_count out  registered counter value (WIDTH)
//   C_out   out  combinational carry: Count & ~Load & (A_count == all ones)
//
// Optional feature: define EXAMPLE_7_SATURATE_EN to make the counter hold at
// all ones instead of wrapping to zero.
module example_7 #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic [WIDTH-1:0] Data_in,
    input  logic             Count,
    input  logic             Load,
    output logic [WIDTH-1:0] A_count,
    output logic             C_out
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] a_count_q;
    logic [WIDTH-1:0] a_count_d;

    // Next value for the non-reset case; Clear is handled in the flop.
    always_comb begin
        a_count_d = a_count_q;
        if (Load) begin
            a_count_d = Data_in;
        end else if (Count) begin
`ifdef EXAMPLE_7_SATURATE_EN
            if (a_count_q != ALL_ONES) begin
                a_count_d = a_count_q + 1'b1;
            end
`else
            a_count_d = a_count_q + 1'b1;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (Clear) begin
            a_count_q <= '0;
        end else begin
            a_count_q <= a_count_d;
        end
    end

    assign A_count = a_count_q;
    // Carry is independent of Clear so a cascade sees the same enable chain
    // whether or not a reset is pending on this edge.
    assign C_out   = Count & ~Load & (a_count_q == ALL_ONES);

endmodule

// File: tb/tb_example_7.sv
module tb_example_7;

    logic       CLK = 1'b0;
    logic       Clear, Load, Count;
    logic [3:0] Data_in;
    logic [3:0] A_count;
    logic       C_out;

    // cascade pair forming an 8-bit counter
    logic       cas_clr, cas_ld, cas_cnt;
    logic [7:0] cas_d;
    logic [3:0] lo_a, hi_a;
    logic       lo_c, hi_c;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    example_7 #(.WIDTH(4)) dut (
        .CLK(CLK), .Clear(Clear), .Data_in(Data_in), .Count(Count),
        .Load(Load), .A_count(A_count), .C_out(C_out)
    );

    example_7 #(.WIDTH(4)) u_lo (
        .CLK(CLK), .Clear(cas_clr), .Data_in(cas_d[3:0]), .Count(cas_cnt),
        .Load(cas_ld), .A_count(lo_a), .C_out(lo_c)
    );

    example_7 #(.WIDTH(4)) u_hi (
        .CLK(CLK), .Clear(cas_clr), .Data_in(cas_d[7:4]), .Count(lo_c),
        .Load(cas_ld), .A_count(hi_a), .C_out(hi_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one edge; inputs change and outputs are sampled 1ns after it
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [3:0] exp_seq [6];

    initial begin
`ifdef EXAMPLE_7_SATURATE_EN
        exp_seq = '{4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'hF};
`else
        exp_seq = '{4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};
`endif
        Clear = 1'b1; Load = 1'b1; Count = 1'b0; Data_in = 4'b1010;
        cas_clr = 1'b1; cas_ld = 1'b0; cas_cnt = 1'b0; cas_d = 8'h00;
        #2;
        tick();
        chk("reset_a", A_count, 4'h0);
        Load = 1'b0;
        #1;
        chk("reset_c", C_out, 1'b0);

        // load beats count
        Clear = 1'b0; Load = 1'b1; Count = 1'b1; Data_in = 4'b1010;
        #1;
        chk("load_c", C_out, 1'b0);
        tick();
        chk("load_a", A_count, 4'hA);

        // count and wrap (or saturate)
        Load = 1'b0; Count = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("cnt_c", C_out, (A_count == 4'hF) ? 1'b1 : 1'b0);
            tick();
            chk("cnt_a", A_count, exp_seq[i]);
        end
        #1;
`ifdef EXAMPLE_7_SATURATE_EN
        chk("sat_c", C_out, 1'b1);
`else
        chk("wrap_c", C_out, 1'b0);
`endif

        // load at all ones together with count: carry forced low
        Load = 1'b1; Count = 1'b0; Data_in = 4'hF;
        tick();
        chk("ld_ff_a", A_count, 4'hF);
        Count = 1'b1; Data_in = 4'b0110;
        #1;
        chk("ld_cnt_c", C_out, 1'b0);
        tick();
        chk("ld_cnt_a", A_count, 4'h6);

        // hold
        Load = 1'b0; Count = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_a", A_count, 4'h6);
            chk("hold_c", C_out, 1'b0);
        end

        // carry ignores Clear; Clear wins on the edge
        Load = 1'b1; Data_in = 4'hF;
        tick();
        Load = 1'b0; Count = 1'b1; Clear = 1'b1;
        #1;
        chk("clr_c", C_out, 1'b1);
        tick();
        chk("clr_a", A_count, 4'h0);

        // mid-count reset
        Clear = 1'b0; Load = 1'b1; Count = 1'b0; Data_in = 4'h4;
        tick();
        Load = 1'b0; Count = 1'b1;
        tick();
        chk("mid_pre", A_count, 4'h5);
        Clear = 1'b1;
        tick();
        chk("mid_clr", A_count, 4'h0);
        Clear = 1'b0;
        tick();
        chk("mid_resume", A_count, 4'h1);

        // cascade 8'h0F -> 8'h10
        cas_clr = 1'b0; cas_ld = 1'b1; cas_d = 8'h0F;
        tick();
        chk("cas_ld", {hi_a, lo_a}, 8'h0F);
        cas_ld = 1'b0; cas_cnt = 1'b1;
        #1;
        chk("cas_lo_c", lo_c, 1'b1);
        tick();
        chk("cas_inc", {hi_a, lo_a}, 8'h10);
        chk("cas_lo_c2", lo_c, 1'b0);

        // cascade top-end carry
        cas_ld = 1'b1; cas_d = 8'hFF;
        tick();
        cas_ld = 1'b0;
        #1;
        chk("cas_hi_c", hi_c, 1'b1);
        tick();
`ifdef EXAMPLE_7_SATURATE_EN
        chk("cas_top", {hi_a, lo_a}, 8'hFF);
`else
        chk("cas_top", {hi_a, lo_a}, 8'h00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
